// File: rtl/video_pack_pkg.sv
// Shared constants for the video packer: packed-word field offsets, colour bars
// and the packed-word width helper.
package video_pack_pkg;

  localparam int SOF_BIT = 0;
  localparam int DE_BIT  = 1;
  localparam int HS_BIT  = 2;
  localparam int VS_BIT  = 3;
  localparam int RGB_LSB = 4;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] COLOR_BARS = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  function automatic int pack_size(input int h_act, input int v_act);
    return 3*8 + 4 + $clog2(h_act) + $clog2(v_act);
  endfunction

endpackage

// File: rtl/video_packer_xy_counter.sv
// Frame-relative x/y pixel counters with saturation, line length / line count
// error detection and the end-of-frame pulse.
module xy_counter
  import video_pack_pkg::*;
#(
  parameter int H_ACT = 1280,
  parameter int V_ACT = 720,
  localparam int XW = $clog2(H_ACT),
  localparam int YW = $clog2(V_ACT)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          de,
  input  logic          prev_de,
  input  logic          vs_rise,
  output logic [XW-1:0] x_cnt,
  output logic [YW-1:0] y_cnt,
  output logic          frame_done,
  output logic [1:0]    err
);

  logic line_full;  // the pixel at x = H_ACT-1 has been consumed on this line
  logic wrapped;    // y wrapped past V_ACT-1 since the last vsync
  logic len_err;
  logic cnt_err;
  logic de_fall;
  logic de_rise;
  logic x_last;
  logic y_last;

  assign de_fall = prev_de & ~de;
  assign de_rise = de & ~prev_de;
  assign x_last  = (x_cnt == XW'(H_ACT - 1));
  assign y_last  = (y_cnt == YW'(V_ACT - 1));
  assign err     = {len_err, cnt_err};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      line_full  <= 1'b0;
      wrapped    <= 1'b0;
      frame_done <= 1'b0;
      len_err    <= 1'b0;
      cnt_err    <= 1'b0;
    end else begin
      frame_done <= de_fall & y_last;
      if ((de && line_full) || (de_fall && !line_full)) len_err <= 1'b1;
      if (de_rise && wrapped) cnt_err <= 1'b1;
      // vsync rise takes priority over the line end; the current pixel has
      // already been packed with the old counters.
      if (vs_rise) begin
        x_cnt     <= '0;
        y_cnt     <= '0;
        line_full <= 1'b0;
        wrapped   <= 1'b0;
      end else if (de_fall) begin
        x_cnt     <= '0;
        line_full <= 1'b0;
        if (y_last) begin
          y_cnt   <= '0;
          wrapped <= 1'b1;
        end else begin
          y_cnt <= y_cnt + 1'b1;
        end
      end else if (de) begin
        if (x_last) line_full <= 1'b1;
        else        x_cnt     <= x_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_packer.sv
// Packs raw RGB video timing into {x, y, R, G, B, vsync, hsync, de, sof}.
// Optional colour-bar generator enabled with VIDEO_PACKER_PATTERN_EN.
module video_packer
  import video_pack_pkg::*;
#(
  parameter logic [11:0] H_ACT  = 12'd1280,
  parameter logic [11:0] V_ACT  = 12'd720,
  parameter logic        HS_POL = 1'b1,
  parameter logic        VS_POL = 1'b1,
  localparam int XW        = $clog2(H_ACT),
  localparam int YW        = $clog2(V_ACT),
  localparam int PACK_SIZE = pack_size(int'(H_ACT), int'(V_ACT))
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_vsync,
  input  logic                 i_hsync,
  input  logic                 i_de,
  input  logic [23:0]          i_rgb,
`ifdef VIDEO_PACKER_PATTERN_EN
  input  logic                 i_pattern,
`endif
  output logic [PACK_SIZE-1:0] o_pack,
  output logic                 o_frame_done,
  output logic [1:0]           o_err
);

  localparam int Y_LSB = RGB_LSB + 24;
  localparam int X_LSB = Y_LSB + YW;

  logic                 vs;
  logic                 hs;
  logic                 prev_de;
  logic                 prev_vs;
  logic [XW-1:0]        x_cnt;
  logic [YW-1:0]        y_cnt;
  logic [23:0]          rgb_src;
  logic [PACK_SIZE-1:0] pack_d;

  assign vs = i_vsync ~^ VS_POL;
  assign hs = i_hsync ~^ HS_POL;

`ifdef VIDEO_PACKER_PATTERN_EN
  logic [2:0] bar_idx;
  assign bar_idx = 3'((int'(x_cnt) * 8) / int'(H_ACT));
  assign rgb_src = i_pattern ? COLOR_BARS[bar_idx] : i_rgb;
`else
  assign rgb_src = i_rgb;
`endif

  xy_counter #(
    .H_ACT (int'(H_ACT)),
    .V_ACT (int'(V_ACT))
  ) u_xy (
    .clk        (clk),
    .rstn       (rstn),
    .de         (i_de),
    .prev_de    (prev_de),
    .vs_rise    (vs & ~prev_vs),
    .x_cnt      (x_cnt),
    .y_cnt      (y_cnt),
    .frame_done (o_frame_done),
    .err        (o_err)
  );

  always_comb begin
    pack_d         = '0;
    pack_d[VS_BIT] = vs;
    pack_d[HS_BIT] = hs;
    pack_d[DE_BIT] = i_de;
    if (i_de) begin
      pack_d[X_LSB +: XW]   = x_cnt;
      pack_d[Y_LSB +: YW]   = y_cnt;
      pack_d[RGB_LSB +: 24] = rgb_src;
      pack_d[SOF_BIT]       = (x_cnt == '0) && (y_cnt == '0);
    end else begin
      // Coordinates hold through blanking; colour is blanked.
      pack_d[X_LSB +: XW] = o_pack[X_LSB +: XW];
      pack_d[Y_LSB +: YW] = o_pack[Y_LSB +: YW];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_pack  <= '0;
      prev_de <= 1'b0;
      prev_vs <= 1'b0;
    end else begin
      o_pack  <= pack_d;
      prev_de <= i_de;
      prev_vs <= vs;
    end
  end

endmodule
